// File: rtl/l2_mem_pkg.sv
// rtl/l2_mem_pkg.sv - shared constants, FSM states and NoC header helpers for l2_mem_responder
package l2_mem_pkg;

   localparam int LINE_WORDS = 8;

   localparam logic [7:0] MSG_LOAD_MEM      = 8'd19;
   localparam logic [7:0] MSG_STORE_MEM     = 8'd20;
   localparam logic [7:0] MSG_LOAD_MEM_ACK  = 8'd24;
   localparam logic [7:0] MSG_STORE_MEM_ACK = 8'd25;

   localparam logic [7:0] LOAD_REQ_LEN  = 8'd2;
   localparam logic [7:0] STORE_REQ_LEN = 8'd10;
   localparam logic [7:0] LOAD_ACK_LEN  = 8'd8;
   localparam logic [7:0] STORE_ACK_LEN = 8'd0;

   typedef enum logic [2:0] {
      S_IDLE, S_RX_HDR, S_RX_DATA, S_DRAIN, S_WAIT, S_TX_HDR, S_TX_DATA
   } state_t;

   // Field order is MSB first: chipid[63:50] ... options[5:0]. Request flit 2 reuses the top three fields.
   typedef struct packed {
      logic [13:0] chipid;
      logic [7:0]  x;
      logic [7:0]  y;
      logic [3:0]  fbits;
      logic [7:0]  len;
      logic [7:0]  msg_type;
      logic [7:0]  mshr;
      logic [5:0]  options;
   } noc_hdr_t;

   function automatic noc_hdr_t hdr_unpack(input logic [63:0] f);
      return noc_hdr_t'(f);
   endfunction

   function automatic logic [63:0] hdr_pack(input noc_hdr_t h);
      return h;
   endfunction

endpackage

// File: rtl/l2_mem_line_store.sv
// rtl/l2_mem_line_store.sv - line-granular word array, synchronous write and combinational read
module l2_mem_line_store
   import l2_mem_pkg::*;
#(
   parameter int LINES = 16,
   parameter int IDX_W = 4
) (
   input  logic               clk,
   input  logic               i_we,
   input  logic [IDX_W+2:0]   i_addr,
   input  logic [63:0]        i_wdata,
   output logic [63:0]        o_rdata
);

   logic [63:0] r_mem [LINES*LINE_WORDS];

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_addr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/l2_mem_responder.sv
// rtl/l2_mem_responder.sv - memory endpoint answering L2 LOAD_MEM/STORE_MEM on NoC2 with ACKs on NoC3
module l2_mem_responder
   import l2_mem_pkg::*;
#(
   parameter int LINES = 16,
   parameter int IDX_W = 4,
   parameter int LAT   = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        noc2_valid_in,
   input  logic [63:0] noc2_data_in,
   output logic        noc2_ready_in,
   output logic        noc3_valid_out,
   output logic [63:0] noc3_data_out,
   input  logic        noc3_ready_out,
   output logic        err_sticky,
   output logic        busy
);

   state_t           r_state, w_next;
   logic             r_live;
   logic [7:0]       r_type, r_mshr, r_len, r_wait;
   logic [8:0]       r_cnt;
   logic [2:0]       r_word;
   logic [IDX_W-1:0] r_idx;
   logic [13:0]      r_src_chip;
   logic [7:0]       r_src_x, r_src_y;
   logic             r_err;

   logic             w_rx_fire, w_tx_fire, w_last_flit, w_hdr_done;
   logic             w_is_load, w_is_store, w_skip_wait, w_we;
   logic [63:0]      w_rdata;
   noc_hdr_t         w_tx_hdr;

   assign w_rx_fire   = noc2_valid_in && noc2_ready_in;
   assign w_tx_fire   = noc3_valid_out && noc3_ready_out;
   // r_cnt counts flits already consumed, so the flit now on the bus is index r_cnt.
   assign w_last_flit = (r_cnt == {1'b0, r_len});
   assign w_hdr_done  = w_rx_fire && ((r_cnt == 9'd2) || w_last_flit);
   assign w_is_load   = (r_type == MSG_LOAD_MEM) && (r_len == LOAD_REQ_LEN);
   assign w_is_store  = (r_type == MSG_STORE_MEM) && (r_len == STORE_REQ_LEN);
   assign w_skip_wait = (LAT == 0);
   assign w_we        = w_rx_fire && (r_state == S_RX_DATA);

   l2_mem_line_store #(.LINES(LINES), .IDX_W(IDX_W)) u_store (
      .clk     (clk),
      .i_we    (w_we),
      .i_addr  ({r_idx, r_word}),
      .i_wdata (noc2_data_in),
      .o_rdata (w_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (w_rx_fire && (hdr_unpack(noc2_data_in).len != 8'd0)) w_next = S_RX_HDR;
         S_RX_HDR:
            if (w_hdr_done) begin
               if (w_is_load)        w_next = w_skip_wait ? S_TX_HDR : S_WAIT;
               else if (w_is_store)  w_next = S_RX_DATA;
               else if (w_last_flit) w_next = S_IDLE;
               else                  w_next = S_DRAIN;
            end
         S_RX_DATA: if (w_rx_fire && (r_word == 3'd7)) w_next = w_skip_wait ? S_TX_HDR : S_WAIT;
         S_DRAIN:   if (w_rx_fire && w_last_flit) w_next = S_IDLE;
         S_WAIT:    if (r_wait <= 8'd1) w_next = S_TX_HDR;
         S_TX_HDR:  if (w_tx_fire) w_next = w_is_load ? S_TX_DATA : S_IDLE;
         S_TX_DATA: if (w_tx_fire && (r_word == 3'd7)) w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_live     <= 1'b0;
         r_type     <= 8'd0;
         r_mshr     <= 8'd0;
         r_len      <= 8'd0;
         r_cnt      <= 9'd0;
         r_word     <= 3'd0;
         r_wait     <= 8'd0;
         r_idx      <= '0;
         r_src_chip <= 14'd0;
         r_src_x    <= 8'd0;
         r_src_y    <= 8'd0;
         r_err      <= 1'b0;
      end else begin
         r_live <= 1'b1;
         if (w_rx_fire) r_cnt <= (r_state == S_IDLE) ? 9'd1 : r_cnt + 9'd1;
         if (w_rx_fire && (r_state == S_IDLE)) begin
            r_type <= hdr_unpack(noc2_data_in).msg_type;
            r_mshr <= hdr_unpack(noc2_data_in).mshr;
            r_len  <= hdr_unpack(noc2_data_in).len;
            if (hdr_unpack(noc2_data_in).len == 8'd0) r_err <= 1'b1;
         end
         if (w_rx_fire && (r_state == S_RX_HDR)) begin
            if (r_cnt == 9'd1) r_idx <= noc2_data_in[6 +: IDX_W];
            if (r_cnt == 9'd2) begin
               r_src_chip <= hdr_unpack(noc2_data_in).chipid;
               r_src_x    <= hdr_unpack(noc2_data_in).x;
               r_src_y    <= hdr_unpack(noc2_data_in).y;
            end
         end
         if (w_hdr_done && (r_state == S_RX_HDR) && !w_is_load && !w_is_store) r_err <= 1'b1;
         if (r_state == S_IDLE)                  r_word <= 3'd0;
         else if (w_we || ((r_state == S_TX_DATA) && w_tx_fire)) r_word <= r_word + 3'd1;
         if ((w_next == S_WAIT) && (r_state != S_WAIT)) r_wait <= LAT[7:0];
         else if (r_state == S_WAIT)                    r_wait <= r_wait - 8'd1;
      end
   end

   always_comb begin
      w_tx_hdr          = '0;
      w_tx_hdr.chipid   = r_src_chip;
      w_tx_hdr.x        = r_src_x;
      w_tx_hdr.y        = r_src_y;
      w_tx_hdr.len      = w_is_load ? LOAD_ACK_LEN : STORE_ACK_LEN;
      w_tx_hdr.msg_type = w_is_load ? MSG_LOAD_MEM_ACK : MSG_STORE_MEM_ACK;
      w_tx_hdr.mshr     = r_mshr;
   end

   always_comb begin
      noc2_ready_in  = r_live && ((r_state == S_IDLE) || (r_state == S_RX_HDR) ||
                                  (r_state == S_RX_DATA) || (r_state == S_DRAIN));
      noc3_valid_out = (r_state == S_TX_HDR) || (r_state == S_TX_DATA);
      case (r_state)
         S_TX_HDR:  noc3_data_out = hdr_pack(w_tx_hdr);
         S_TX_DATA: noc3_data_out = w_rdata;
         default:   noc3_data_out = 64'd0;
      endcase
      busy       = (r_state != S_IDLE);
      err_sticky = r_err;
   end

endmodule

// File: tb/tb_l2_mem_responder.sv
// tb/tb_l2_mem_responder.sv - self-checking bench for l2_mem_responder (LAT=0 and LAT=7 instances)
module tb_l2_mem_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, sel, in_valid, out_ready;
   logic [63:0] in_data;
   logic        rdy0, rdy7, v0, v7, err0, err7, busy0, busy7;
   logic [63:0] d0, d7;
   logic        cur_ready, cur_valid, cur_err, cur_busy;
   logic [63:0] cur_data;

   l2_mem_responder #(.LINES(16), .IDX_W(4), .LAT(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n),
      .noc2_valid_in(in_valid && !sel), .noc2_data_in(in_data), .noc2_ready_in(rdy0),
      .noc3_valid_out(v0), .noc3_data_out(d0), .noc3_ready_out(out_ready && !sel),
      .err_sticky(err0), .busy(busy0)
   );

   l2_mem_responder #(.LINES(16), .IDX_W(4), .LAT(7)) u_dut7 (
      .clk(clk), .rst_n(rst_n),
      .noc2_valid_in(in_valid && sel), .noc2_data_in(in_data), .noc2_ready_in(rdy7),
      .noc3_valid_out(v7), .noc3_data_out(d7), .noc3_ready_out(out_ready && sel),
      .err_sticky(err7), .busy(busy7)
   );

   assign cur_ready = sel ? rdy7 : rdy0;
   assign cur_valid = sel ? v7 : v0;
   assign cur_data  = sel ? d7 : d0;
   assign cur_err   = sel ? err7 : err0;
   assign cur_busy  = sel ? busy7 : busy0;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          t_acc    = 0;
   logic [63:0] model_mem [2][16][8];
   logic [63:0] tx_q[$];
   logic [63:0] exp_q[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] hdr(input logic [13:0] chip, input logic [7:0] x, input logic [7:0] y,
                                       input logic [7:0] len, input logic [7:0] typ, input logic [7:0] mshr);
      return {chip, x, y, 4'd0, len, typ, mshr, 6'd0};
   endfunction

   function automatic int line_of(input logic [39:0] addr);
      return int'((addr >> 6) % 16);
   endfunction

   task automatic send_q();
      int guard = 0;
      in_valid = 1'b1;
      while (tx_q.size() > 0) begin
         logic acc;
         in_data = tx_q[0];
         acc = cur_ready;
         if (acc) t_acc = cyc;
         @(posedge clk); #1;
         if (acc) void'(tx_q.pop_front());
         guard++;
         if (guard > 300) begin
            check("send_timeout", 64'd1, 64'd0);
            tx_q.delete();
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic collect(input int n, input bit bp, input int lat_exp);
      int          got = 0;
      int          guard = 0;
      bit          first = 1'b1;
      logic        stalled = 1'b0;
      logic [63:0] held = '0;
      while (got < n && guard < 500) begin
         if (stalled) check("valid_held", 64'(cur_valid), 64'd1);
         if (cur_valid) begin
            if (first && lat_exp >= 0) check("latency", 64'(cyc - t_acc), 64'(lat_exp));
            first = 1'b0;
            if (stalled) check("stable_under_bp", cur_data, held);
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_ready) begin
               check("resp_flit", cur_data, exp_q.pop_front());
               got++;
            end
            stalled = !out_ready;
            held    = cur_data;
         end else begin
            out_ready = 1'($urandom_range(0, 1));
            stalled   = 1'b0;
         end
         @(posedge clk); #1;
         guard++;
      end
      out_ready = 1'b0;
      if (got < n) check("collect_timeout", 64'(got), 64'(n));
   endtask

   task automatic do_store(input logic [39:0] addr, input logic [7:0] mshr, input bit seq, input bit bp);
      int          idx = line_of(addr);
      logic [13:0] chip = 14'($urandom);
      logic [7:0]  x = 8'($urandom);
      logic [7:0]  y = 8'($urandom);
      logic [63:0] w;
      tx_q.push_back(hdr(14'd0, 8'd0, 8'd0, 8'd10, 8'd20, mshr));
      tx_q.push_back(64'(addr));
      tx_q.push_back({chip, x, y, 34'd0});
      for (int i = 0; i < 8; i++) begin
         w = seq ? 64'h1000 + 64'(i) : {$urandom, $urandom};
         model_mem[sel][idx][i] = w;
         tx_q.push_back(w);
      end
      exp_q.push_back(hdr(chip, x, y, 8'd0, 8'd25, mshr));
      send_q();
      collect(1, bp, -1);
      check("busy_after_store", 64'(cur_busy), 64'd0);
   endtask

   task automatic issue_load(input logic [39:0] addr, input logic [7:0] mshr, input logic [7:0] x, input logic [7:0] y);
      int          idx = line_of(addr);
      logic [13:0] chip = 14'($urandom);
      tx_q.push_back(hdr(14'd0, 8'd0, 8'd0, 8'd2, 8'd19, mshr));
      tx_q.push_back(64'(addr));
      tx_q.push_back({chip, x, y, 34'd0});
      exp_q.push_back(hdr(chip, x, y, 8'd8, 8'd24, mshr));
      for (int i = 0; i < 8; i++) exp_q.push_back(model_mem[sel][idx][i]);
      send_q();
   endtask

   task automatic do_load(input logic [39:0] addr, input logic [7:0] mshr, input logic [7:0] x, input logic [7:0] y,
                          input bit bp, input int lat_exp);
      issue_load(addr, mshr, x, y);
      collect(9, bp, lat_exp);
      check("busy_after_load", 64'(cur_busy), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bit          saw;
      int          line;
      logic [39:0] a;
      rst_n = 1'b0; sel = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", 64'(cur_ready), 64'd0);
      check("rst_valid", 64'(cur_valid), 64'd0);
      check("rst_data", cur_data, 64'd0);
      check("rst_err", 64'(cur_err), 64'd0);
      check("rst_busy", 64'(cur_busy), 64'd0);
      #2 rst_n = 1'b1;
      check("ready_reset_cycle", 64'(cur_ready), 64'd0);
      @(posedge clk); #1;
      check("ready_idle", 64'(cur_ready), 64'd1);

      do_store(40'h40, 8'h05, 1'b1, 1'b0);
      do_load(40'h40, 8'h06, 8'd2, 8'd3, 1'b0, 8);

      sel = 1'b0;
      do_store(40'h80, 8'h11, 1'b0, 1'b0);
      do_load(40'h80, 8'h12, 8'd4, 8'd5, 1'b0, 1);
      sel = 1'b1;

      do_load(40'h40, 8'h21, 8'd7, 8'd1, 1'b1, -1);

      tx_q.push_back(hdr(14'd0, 8'd0, 8'd0, 8'd3, 8'h7F, 8'h33));
      for (int i = 0; i < 3; i++) tx_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
      send_q();
      saw = 1'b0;
      repeat (20) begin
         saw |= cur_valid;
         @(posedge clk); #1;
      end
      check("err_no_noc3", 64'(saw), 64'd0);
      check("err_sticky", 64'(cur_err), 64'd1);
      check("err_drained", 64'(cur_busy), 64'd0);
      do_load(40'h40, 8'h34, 8'd9, 8'd8, 1'b0, 8);

      do_store(40'h000, 8'h41, 1'b0, 1'b0);
      do_load(40'h400, 8'h42, 8'd1, 8'd1, 1'b0, -1);

      for (int k = 0; k < 6; k++) begin
         line = $urandom_range(0, 15);
         a = {$urandom, 8'($urandom)};
         a[9:6] = 4'(line);
         do_store(a, 8'($urandom), 1'b0, 1'($urandom_range(0, 1)));
         a[39:10] = 30'($urandom);
         a[5:0]   = 6'($urandom);
         do_load(a, 8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), -1);
      end

      issue_load(40'h40, 8'h51, 8'd6, 8'd6);
      collect(4, 1'b0, -1);
      check("pre_rst_valid", 64'(cur_valid), 64'd1);
      check("pre_rst_word3", cur_data, model_mem[1][1][3]);
      rst_n = 1'b0;
      #1;
      check("rst_tx_valid_drop", 64'(cur_valid), 64'd0);
      exp_q.delete();
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_busy", 64'(cur_busy), 64'd0);
      check("post_rst_err", 64'(cur_err), 64'd0);
      do_load(40'h40, 8'h52, 8'd2, 8'd2, 1'b0, 8);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
